// File: rtl/br_reader.sv
// Register-file dump engine: walks the 32-entry file two registers per clock
// through RR1/RR2 and streams tagged words out of a small FIFO.
module br_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] RR1,
  output logic [ADDR_W-1:0] RR2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_reg,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] REM_1   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_2   = (ADDR_W+1)'(2);
  localparam logic [PTR_W:0]  DEPTH_P = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  OCC_1   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]  OCC_2   = (PTR_W+1)'(2);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              done_q, done_d;
  logic [PTR_W:0]    wr_q, wr_d, rd_q, rd_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];

  logic [PTR_W:0]    occ, free;
  logic [PTR_W-1:0]  wr_idx0, wr_idx1;
  logic [ADDR_W-1:0] rr2_addr;
  logic [ENT_W-1:0]  head;
  logic              pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ      = wr_q - rd_q;
  assign free     = DEPTH_P - occ;
  assign wr_idx0  = wr_q[PTR_W-1:0];
  assign wr_idx1  = wr_idx0 + PTR_W'(1);
  assign rr2_addr = ptr_q + ADDR_W'(1);
  assign head     = mem_q[rd_q[PTR_W-1:0]];

  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_reg   = out_valid ? head[DATA_W +: ADDR_W] : '0;
  assign out_last  = out_valid & head[ENT_W-1];

  assign RR1  = (state_q == S_READ) ? ptr_q : '0;
  assign RR2  = (state_q == S_READ) ? rr2_addr : '0;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wr_d        = wr_q;
    rd_d        = rd_q + (PTR_W+1)'(pop);
    mem_d       = mem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d       = first_reg;
          remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
          state_d     = (count == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        // Space is judged before any pop this cycle, so a pop never unblocks a push early.
        if (remaining_q >= REM_2 && free >= OCC_2) begin
          mem_d[wr_idx0] = {1'b0, ptr_q, RD1};
          mem_d[wr_idx1] = {(remaining_q == REM_2), rr2_addr, RD2};
          wr_d           = wr_q + OCC_2;
          ptr_d          = ptr_q + ADDR_W'(2);
          remaining_d    = remaining_q - REM_2;
        end else if (remaining_q == REM_1 && free >= OCC_1) begin
          mem_d[wr_idx0] = {1'b1, ptr_q, RD1};
          wr_d           = wr_q + OCC_1;
          ptr_d          = ptr_q + ADDR_W'(1);
          remaining_d    = '0;
        end
        if (remaining_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (occ == '0 || (occ == OCC_1 && pop)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
